// File: rtl/calendar_display_pkg.sv
// Shared constants for the calendar display: 1080p60 raster timing
// and character cell geometry used by the renderer.
package calendar_display_pkg;

    localparam int DEF_H_ACTIVE = 1920;
    localparam int DEF_H_FP     = 88;
    localparam int DEF_H_SYNC   = 44;
    localparam int DEF_H_BP     = 148;

    localparam int DEF_V_ACTIVE = 1080;
    localparam int DEF_V_FP     = 4;
    localparam int DEF_V_SYNC   = 5;
    localparam int DEF_V_BP     = 36;

    localparam int CHAR_WIDTH   = 32;
    localparam int CHAR_HEIGHT  = 32;

    // 12 bits cover the largest total (2200) of the default timing
    localparam int CNT_W        = 12;

    function automatic int span_total(
        input int active,
        input int fp,
        input int sync,
        input int bp
    );
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// 1-bit shift register that delays a sync signal by DEPTH clocks;
// every stage resets to INIT, DEPTH = 0 passes straight through.
module sync_delay_line #(
    parameter int   DEPTH = 2,
    parameter logic INIT  = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk_i ^ rst_i;
            assign q_o = d_i;
        end else begin : g_shift
            logic [DEPTH-1:0] sr_q;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    sr_q <= {DEPTH{INIT}};
                end else begin
                    sr_q[0] <= d_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        sr_q[i] <= sr_q[i-1];
                    end
                end
            end

            assign q_o = sr_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: scan counters, registered position/strobe decode,
// delayed panel syncs and a wrapping frame counter.
module vga_timing_gen
    import calendar_display_pkg::*;
#(
    parameter int   H_ACTIVE   = DEF_H_ACTIVE,
    parameter int   H_FP       = DEF_H_FP,
    parameter int   H_SYNC     = DEF_H_SYNC,
    parameter int   H_BP       = DEF_H_BP,
    parameter int   V_ACTIVE   = DEF_V_ACTIVE,
    parameter int   V_FP       = DEF_V_FP,
    parameter int   V_SYNC     = DEF_V_SYNC,
    parameter int   V_BP       = DEF_V_BP,
    parameter logic HS_POL     = 1'b1,
    parameter logic VS_POL     = 1'b1,
    parameter int   SYNC_DELAY = 2
) (
    input  logic        clk_148_5MHz,
    input  logic        reset,
    output logic [31:0] pixel_x,
    output logic [31:0] pixel_y,
    output logic        video_on,
    output logic        hsync,
    output logic        vsync,
    output logic        line_start,
    output logic        frame_start,
    output logic [7:0]  frame_count
);

    localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic [CNT_W-1:0] x_q, y_q;
    logic             von_q, von_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             ls_q, ls_d;
    logic             fs_q, fs_d;
    logic [7:0]       fc_q, fc_d;
    logic             started_q;

    always_comb begin
        h_d  = '0;
        v_d  = v_q;
        von_d = 1'b0;
        hs_d = ~HS_POL;
        vs_d = ~VS_POL;
        ls_d = 1'b0;
        fs_d = 1'b0;
        fc_d = fc_q;

        // Out-of-range counts fall back to 0 through the same wrap path
        if (h_q < H_LAST) begin
            h_d = h_q + CNT_W'(1);
        end else begin
            v_d = '0;
            if (v_q < V_LAST) begin
                v_d = v_q + CNT_W'(1);
            end
        end

        von_d = (h_q < H_ACT) && (v_q < V_ACT);
        if ((h_q >= HS_BEG) && (h_q < HS_END)) begin
            hs_d = HS_POL;
        end
        if ((v_q >= VS_BEG) && (v_q < VS_END)) begin
            vs_d = VS_POL;
        end
        ls_d = (h_q == '0);
        fs_d = ls_d && (v_q == '0);

        // The frame_start right after reset opens frame 0; it is not a completion
        if (fs_d && started_q) begin
            fc_d = fc_q + 8'd1;
        end
    end

    always_ff @(posedge clk_148_5MHz) begin
        if (reset) begin
            h_q       <= '0;
            v_q       <= '0;
            x_q       <= '0;
            y_q       <= '0;
            von_q     <= 1'b0;
            hs_q      <= ~HS_POL;
            vs_q      <= ~VS_POL;
            ls_q      <= 1'b0;
            fs_q      <= 1'b0;
            fc_q      <= 8'd0;
            started_q <= 1'b0;
        end else begin
            h_q   <= h_d;
            v_q   <= v_d;
            x_q   <= h_q;
            y_q   <= v_q;
            von_q <= von_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            ls_q  <= ls_d;
            fs_q  <= fs_d;
            fc_q  <= fc_d;
            if (fs_d) begin
                started_q <= 1'b1;
            end
        end
    end

    sync_delay_line #(
        .DEPTH (SYNC_DELAY),
        .INIT  (~HS_POL)
    ) u_hs_delay (
        .clk_i (clk_148_5MHz),
        .rst_i (reset),
        .d_i   (hs_q),
        .q_o   (hsync)
    );

    sync_delay_line #(
        .DEPTH (SYNC_DELAY),
        .INIT  (~VS_POL)
    ) u_vs_delay (
        .clk_i (clk_148_5MHz),
        .rst_i (reset),
        .d_i   (vs_q),
        .q_o   (vsync)
    );

    assign pixel_x     = {{(32-CNT_W){1'b0}}, x_q};
    assign pixel_y     = {{(32-CNT_W){1'b0}}, y_q};
    assign video_on    = von_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign frame_count = fc_q;

endmodule
